// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_t : sequencer states (RUN, MEM_WAIT, HALT)
//   REG_X0  : architectural zero register index, never a real hazard source
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low clear
//   inc     : count one event this cycle
//   count   : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RISC-V pipeline.
// Handles load-use interlock, EX control redirect and data-memory wait with
// timeout; drives every pipeline-register enable, flush and the MEM/WB bubble.
// Ports:
//   clk, reset_n                   : clock, synchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2    : ID source registers and their use flags
//   ex_lw, ex_esc_reg_n, ex_rd     : EX load flag, active-low write enable, rd
//   ex_redirect                    : EX taken branch / jal / jalr
//   mem_req, mem_ready             : MEM data access request / completion
//   pc_en .. ex_mem_en             : pipeline register load enables
//   if_id_flush, id_ex_flush       : bubble insertion into IF/ID, ID/EX
//   mem_wb_bubble                  : MEM/WB captures a nop
//   mem_err                        : sticky memory timeout flag
//   stall_cycles, flush_events     : saturating performance counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_lw,
  input  logic             ex_esc_reg_n,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  // The RUN cycle that first sees the stall is itself a stalled cycle, so
  // the halt fires on the edge where the counter would reach MEM_TIMEOUT-1,
  // i.e. after MEM_TIMEOUT consecutive stalled cycles in total.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic lu;
  logic ms;
  logic active;
  logic stall_inc;
  logic flush_inc;

  assign lu = ex_lw && !ex_esc_reg_n && (ex_rd != REG_X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
  assign ms = mem_req && !mem_ready;

  assign active    = reset_n && (state != HALT);
  assign stall_inc = active && (ms || (lu && !ex_redirect));
  assign flush_inc = active && !ms && ex_redirect;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if ((state == HALT) || ms) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      // Redirect wins over load-use: the dependent instruction is squashed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ms) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!ms) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST) begin
              state   <= HALT;
              mem_err <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .count   (flush_events)
  );

endmodule
